// File: rtl/gen_reg_acc_pkg.sv
// Shared select encodings, FSM state type and half-word width for the
// general register access controller.
package gen_reg_acc_pkg;

  localparam logic [1:0] SEL_FULL = 2'b00;
  localparam logic [1:0] SEL_HIGH = 2'b01;
  localparam logic [1:0] SEL_LOW  = 2'b10;
  localparam logic [1:0] SEL_RSVD = 2'b11;

  localparam int DATA_W = 20;
  localparam int HALF_W = DATA_W / 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_RESP
  } state_t;

endpackage

// File: rtl/gen_reg_half_merge.sv
// Combinational half-word merge (for read-modify-write) and extract/extend.
// Macro GEN_REG_ACC_SIGN_EXT_EN selects sign extension of extracted halves.
module gen_reg_half_merge
  import gen_reg_acc_pkg::*;
#(
  parameter int DATA_W = 20
) (
  input  logic [DATA_W-1:0]   word,
  input  logic [DATA_W/2-1:0] half,
  input  logic [1:0]          sel,
  output logic [DATA_W-1:0]   merged,
  output logic [DATA_W-1:0]   extracted
);

  localparam int HW = DATA_W / 2;

  logic [HW-1:0] h;

  always_comb begin
    merged = word;
    h      = word[HW-1:0];
    case (sel)
      SEL_HIGH: begin
        merged = {half, word[HW-1:0]};
        h      = word[DATA_W-1:HW];
      end
      SEL_LOW:  merged = {word[DATA_W-1:HW], half};
      default:  ;
    endcase
`ifdef GEN_REG_ACC_SIGN_EXT_EN
    extracted = {{HW{h[HW-1]}}, h};
`else
    extracted = {{HW{1'b0}}, h};
`endif
    if (sel == SEL_FULL) extracted = word;
  end

endmodule

// File: rtl/gen_reg_access_ctrl.sv
// Single-outstanding register-file access initiator with half-word RMW.
// Optional macro GEN_REG_ACC_SIGN_EXT_EN: sign-extend half-word reads.
module gen_reg_access_ctrl
  import gen_reg_acc_pkg::*;
#(
  parameter int DATA_W   = 20,
  parameter int ADDR_W   = 10,
  parameter int NUM_REGS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_sel,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              rf_re,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata
);

  localparam int HW = DATA_W / 2;

  state_t            st, st_nxt;
  logic              wr_q, err_q, bad;
  logic [1:0]        sel_q;
  logic [HW-1:0]     hw_q;
  logic [DATA_W-1:0] merged, extracted;

  assign bad = (req_addr >= ADDR_W'(NUM_REGS)) || (req_sel == SEL_RSVD);

  // rf_rdata is only meaningful in CAP, so it feeds the merge unit directly
  gen_reg_half_merge #(.DATA_W(DATA_W)) u_merge (
    .word      (rf_rdata),
    .half      (hw_q),
    .sel       (sel_q),
    .merged    (merged),
    .extracted (extracted)
  );

  always_ff @(posedge clk) begin
    if (rst) st <= ST_IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt     = st;
    req_ready  = 1'b0;
    rf_re      = 1'b0;
    rf_we      = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    case (st)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (bad)                                st_nxt = ST_RESP;
          else if (req_write && req_sel == SEL_FULL) st_nxt = ST_WR;
          else                                    st_nxt = ST_RD;
        end
      end
      ST_RD:  begin rf_re = 1'b1; st_nxt = ST_CAP; end
      ST_CAP: st_nxt = wr_q ? ST_WR : ST_RESP;
      ST_WR:  begin rf_we = 1'b1; st_nxt = ST_RESP; end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (resp_ready) st_nxt = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  // Datapath: resp_data/rf_wdata are only loaded on state transitions so
  // they stay stable through RESP backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      sel_q     <= SEL_FULL;
      hw_q      <= '0;
      resp_data <= '0;
      rf_addr   <= '0;
      rf_wdata  <= '0;
    end else begin
      case (st)
        ST_IDLE: if (req_valid) begin
          wr_q  <= req_write;
          sel_q <= req_sel;
          hw_q  <= req_wdata[HW-1:0];
          err_q <= bad;
          if (bad) resp_data <= '0;
          else begin
            rf_addr <= req_addr;
            if (req_write && req_sel == SEL_FULL) rf_wdata <= req_wdata;
          end
        end
        ST_CAP: begin
          if (wr_q) rf_wdata  <= merged;
          else      resp_data <= extracted;
        end
        ST_WR:   resp_data <= rf_wdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gen_reg_access_ctrl.sv
// Scoreboard bench for gen_reg_access_ctrl with a 6-entry register-file model.
module tb_gen_reg_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [1:0]  req_sel;
  logic [9:0]  req_addr;
  logic [19:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [19:0] resp_data;
  logic        rf_re, rf_we;
  logic [9:0]  rf_addr;
  logic [19:0] rf_wdata, rf_rdata;

  typedef struct {
    logic [19:0] d;
    logic        e;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int re_cyc, we_cyc, rsp_cyc, nre, nwe;
  logic [19:0] we_dat;

  logic [19:0] rf_mem [0:5] = '{default: 20'h0};

  always #5 clk = ~clk;

  gen_reg_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .rf_re(rf_re), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  // register file: read data valid the cycle after rf_re
  always @(posedge clk) begin
    if (rf_we && rf_addr < 10'd6) rf_mem[rf_addr] <= rf_wdata;
    rf_rdata <= (rf_re && rf_addr < 10'd6) ? rf_mem[rf_addr] : 20'h0;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drives one request, tracks strobes per cycle after acceptance (c=1 is N+1),
  // and pops the scoreboard on the response handshake.
  task automatic run_req(input string tag, input logic w, input logic [1:0] s,
                         input logic [9:0] a, input logic [19:0] d,
                         input logic [19:0] ed, input logic ee,
                         input int e_re, input int e_we, input logic [19:0] e_wd,
                         input int e_rsp, input int hold);
    exp_t ex, got;
    int held = 0;
    bit done = 0;
    logic [19:0] first = '0;
    @(negedge clk);
    chk({tag, "_rdy"}, req_ready, 1);
    req_valid = 1; req_write = w; req_sel = s; req_addr = a; req_wdata = d;
    resp_ready = 0;
    ex.d = ed; ex.e = ee;
    exp_q.push_back(ex);
    @(posedge clk);
    #1 req_valid = 0;
    re_cyc = -1; we_cyc = -1; rsp_cyc = -1; nre = 0; nwe = 0; we_dat = '0;
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge clk);
      if (rf_re) begin nre++; if (re_cyc < 0) re_cyc = c; end
      if (rf_we) begin nwe++; we_cyc = c; we_dat = rf_wdata; end
      if (resp_valid) begin
        if (rsp_cyc < 0) begin
          rsp_cyc = c; first = resp_data;
        end else begin
          chk({tag, "_stable"}, resp_data, first);
          chk({tag, "_rdy_low"}, req_ready, 0);
        end
        if (held == hold) begin
          resp_ready = 1;
          got.d = resp_data; got.e = resp_err;
          ex = exp_q.pop_front();
          chk({tag, "_data"}, got.d, ex.d);
          chk({tag, "_err"}, got.e, ex.e);
          @(posedge clk);
          #1 resp_ready = 0;
          @(negedge clk);
          chk({tag, "_rdy_after"}, req_ready, 1);
          done = 1;
        end else held++;
      end
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_re_cyc"}, re_cyc, e_re);
    chk({tag, "_we_cyc"}, we_cyc, e_we);
    if (e_we > 0) chk({tag, "_wdata"}, we_dat, e_wd);
    chk({tag, "_rsp_cyc"}, rsp_cyc, e_rsp);
  endtask

  initial begin
    logic [19:0] lo_exp, hi_exp;
`ifdef GEN_REG_ACC_SIGN_EXT_EN
    lo_exp = 20'hFFF0F; hi_exp = 20'hFFFC3;
`else
    lo_exp = 20'h0030F; hi_exp = 20'h003C3;
`endif
    rst = 1; req_valid = 0; req_write = 0; req_sel = 0; req_addr = 0;
    req_wdata = 0; resp_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_rf_re", rf_re, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);

    // a valid pulse that is not accepted would still be accepted in IDLE,
    // so just confirm an idle bus produces no activity
    repeat (3) begin
      @(negedge clk);
      chk("idle_quiet", {rf_re, rf_we, resp_valid}, 3'b000);
    end

    run_req("wr_full_r0", 1, 2'b00, 10'd0, 20'hAAAAA, 20'hAAAAA, 0, -1, 1, 20'hAAAAA, 2, 0);
    run_req("rd_full_r0", 0, 2'b00, 10'd0, 20'h0,     20'hAAAAA, 0, 1, -1, 20'h0, 3, 0);
    run_req("wr_full_r2", 1, 2'b00, 10'd2, 20'hF0F0F, 20'hF0F0F, 0, -1, 1, 20'hF0F0F, 2, 0);
    run_req("wr_hi_r1",   1, 2'b01, 10'd1, 20'h00333, 20'hCCC00, 0, 1, 3, 20'hCCC00, 4, 0);
    run_req("rd_lo_r2",   0, 2'b10, 10'd2, 20'h0,     lo_exp,    0, 1, -1, 20'h0, 3, 0);
    run_req("rd_hi_r2",   0, 2'b01, 10'd2, 20'h0,     hi_exp,    0, 1, -1, 20'h0, 3, 0);
    run_req("err_addr6",  0, 2'b00, 10'd6, 20'h0,     20'h0,     1, -1, -1, 20'h0, 1, 0);
    chk("err_addr6_nstrobe", nre + nwe, 0);
    run_req("err_sel11",  1, 2'b11, 10'd0, 20'h12345, 20'h0,     1, -1, -1, 20'h0, 1, 0);
    chk("err_sel11_nstrobe", nre + nwe, 0);
    run_req("bp_rd_r0",   0, 2'b00, 10'd0, 20'h0,     20'hAAAAA, 0, 1, -1, 20'h0, 3, 3);
    run_req("wr_lo_r0",   1, 2'b10, 10'd0, 20'hFF155, 20'hAA955, 0, 1, 3, 20'hAA955, 4, 0);
    run_req("rd_full_r0b",0, 2'b00, 10'd0, 20'h0,     20'hAA955, 0, 1, -1, 20'h0, 3, 0);

    // reset during CAP of a half write to r1: write must be abandoned
    @(negedge clk);
    req_valid = 1; req_write = 1; req_sel = 2'b10; req_addr = 10'd1; req_wdata = 20'h003FF;
    @(posedge clk);          // accept (N)
    #1 req_valid = 0;        // N+1: RD
    @(posedge clk);
    #1 rst = 1;              // N+2: CAP
    chk("rstcap_we", rf_we, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rstcap_idle", req_ready, 1);
    nwe = 0;
    repeat (4) begin
      if (rf_we) nwe++;
      @(negedge clk);
    end
    chk("rstcap_no_we", nwe, 0);
    run_req("rd_r1_after_rst", 0, 2'b00, 10'd1, 20'h0, 20'hCCC00, 0, 1, -1, 20'h0, 3, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
